// File: rtl/core_axi_master_pkg.sv
// Shared types and AXI encodings for the core data port to AXI4 master bridge.
package core_axi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_B,
        READ,
        WAIT_R,
        RESP
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B      = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR  = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return !(resp == AXI_RESP_OKAY || resp == AXI_RESP_EXOKAY);
    endfunction

endpackage

// File: rtl/core_data_axi_master.sv
// Turns core req/gnt/rvalid data accesses into single-beat AXI4 transactions,
// one outstanding at a time.
//
// state  | meaning
// IDLE   | waiting for a core request; gnt follows req
// WRITE  | AW and W presented, each dropped after its own handshake
// WAIT_B | waiting for the write response
// READ   | AR presented until accepted
// WAIT_R | waiting for the read data beat
// RESP   | one-cycle rvalid back to the core
module core_data_axi_master
    import core_axi_master_pkg::*;
#(
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiDataWidth = 32,
    parameter int unsigned AxiIdWidth   = 8,
    parameter int unsigned AxiUserWidth = 8,
    parameter int unsigned AxiId        = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    input  logic [AxiAddrWidth-1:0]   data_addr_i,
    input  logic                      data_we_i,
    input  logic [AxiDataWidth/8-1:0] data_be_i,
    input  logic [AxiDataWidth-1:0]   data_wdata_i,
    output logic                      data_rvalid_o,
    output logic [AxiDataWidth-1:0]   data_rdata_o,
    output logic                      data_err_o,

    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,
    output logic [AxiAddrWidth-1:0]   aw_addr_o,
    output logic [AxiIdWidth-1:0]     aw_id_o,
    output logic [7:0]                aw_len_o,
    output logic [2:0]                aw_size_o,
    output logic [1:0]                aw_burst_o,
    output logic [2:0]                aw_prot_o,
    output logic [AxiUserWidth-1:0]   aw_user_o,

    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    output logic [AxiDataWidth-1:0]   w_data_o,
    output logic [AxiDataWidth/8-1:0] w_strb_o,
    output logic                      w_last_o,
    output logic [AxiUserWidth-1:0]   w_user_o,

    input  logic                      b_valid_i,
    output logic                      b_ready_o,
    input  logic [AxiIdWidth-1:0]     b_id_i,
    input  logic [1:0]                b_resp_i,

    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,
    output logic [AxiAddrWidth-1:0]   ar_addr_o,
    output logic [AxiIdWidth-1:0]     ar_id_o,
    output logic [7:0]                ar_len_o,
    output logic [2:0]                ar_size_o,
    output logic [1:0]                ar_burst_o,
    output logic [2:0]                ar_prot_o,
    output logic [AxiUserWidth-1:0]   ar_user_o,

    input  logic                      r_valid_i,
    output logic                      r_ready_o,
    input  logic [AxiDataWidth-1:0]   r_data_i,
    input  logic [AxiIdWidth-1:0]     r_id_i,
    input  logic [1:0]                r_resp_i,
    input  logic                      r_last_i
);

    if (AxiDataWidth != 32) begin : g_width_check
        $error("core_data_axi_master supports only AxiDataWidth == 32");
    end

    localparam logic [AxiIdWidth-1:0] ID = AxiIdWidth'(AxiId);

    state_e                      state;
    logic [AxiAddrWidth-1:0]     addr_q;
    logic [AxiDataWidth/8-1:0]   be_q;
    logic [AxiDataWidth-1:0]     wdata_q;
    logic                        aw_valid_q;
    logic                        w_valid_q;
    logic                        ar_valid_q;
    logic                        b_ready_q;
    logic                        r_ready_q;
    logic                        rvalid_q;
    logic                        err_q;
    logic [AxiDataWidth-1:0]     rdata_q;
    logic                        aw_done;
    logic                        w_done;

    // A channel counts as done if it already dropped valid or handshakes now.
    always_comb begin
        aw_done = !aw_valid_q || aw_ready_i;
        w_done  = !w_valid_q  || w_ready_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            r_ready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req_i) begin
                        addr_q  <= data_addr_i;
                        be_q    <= data_be_i;
                        wdata_q <= data_wdata_i;
                        if (data_we_i) begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            state      <= WRITE;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state      <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (aw_ready_i) aw_valid_q <= 1'b0;
                    if (w_ready_i)  w_valid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        b_ready_q <= 1'b1;
                        state     <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (b_valid_i) begin
                        b_ready_q <= 1'b0;
                        err_q     <= resp_is_err(b_resp_i);
                        rdata_q   <= '0;
                        rvalid_q  <= 1'b1;
                        state     <= RESP;
                    end
                end
                READ: begin
                    if (ar_ready_i) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state      <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (r_valid_i) begin
                        r_ready_q <= 1'b0;
                        err_q     <= resp_is_err(r_resp_i);
                        // Error beats carry no meaningful data; never leak it to the core.
                        rdata_q   <= resp_is_err(r_resp_i) ? '0 : r_data_i;
                        rvalid_q  <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign data_gnt_o    = (state == IDLE) && data_req_i;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;

    assign aw_valid_o = aw_valid_q;
    assign aw_addr_o  = addr_q;
    assign aw_id_o    = ID;
    assign aw_len_o   = 8'd0;
    assign aw_size_o  = AXI_SIZE_4B;
    assign aw_burst_o = AXI_BURST_INCR;
    assign aw_prot_o  = 3'b000;
    assign aw_user_o  = '0;

    assign w_valid_o = w_valid_q;
    assign w_data_o  = wdata_q;
    assign w_strb_o  = be_q;
    assign w_last_o  = 1'b1;
    assign w_user_o  = '0;

    assign b_ready_o = b_ready_q;

    assign ar_valid_o = ar_valid_q;
    assign ar_addr_o  = addr_q;
    assign ar_id_o    = ID;
    assign ar_len_o   = 8'd0;
    assign ar_size_o  = AXI_SIZE_4B;
    assign ar_burst_o = AXI_BURST_INCR;
    assign ar_prot_o  = 3'b000;
    assign ar_user_o  = '0;

    assign r_ready_o = r_ready_q;

    a_b_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (b_valid_i && b_ready_o) |-> (b_id_i == ID));
    a_r_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_valid_i && r_ready_o) |-> (r_id_i == ID));
    a_r_last: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_valid_i && r_ready_o) |-> r_last_i);
    a_aw_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (aw_valid_o && !aw_ready_i) |=> aw_valid_o);
    a_w_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_valid_o && !w_ready_i) |=> w_valid_o);
    a_ar_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ar_valid_o && !ar_ready_i) |=> ar_valid_o);

endmodule

// File: tb/tb_core_data_axi_master.sv
// Scoreboard bench for core_data_axi_master with a configurable AXI slave model.
module tb_core_data_axi_master;
    import core_axi_master_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        data_req_i = 0, data_we_i = 0;
    logic [31:0] data_addr_i = 0, data_wdata_i = 0;
    logic [3:0]  data_be_i = 0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        aw_valid_o, aw_ready_i = 0;
    logic [31:0] aw_addr_o;
    logic [7:0]  aw_id_o, aw_len_o, aw_user_o;
    logic [2:0]  aw_size_o, aw_prot_o;
    logic [1:0]  aw_burst_o;
    logic        w_valid_o, w_ready_i = 0, w_last_o;
    logic [31:0] w_data_o;
    logic [3:0]  w_strb_o;
    logic [7:0]  w_user_o;
    logic        b_valid_i = 0, b_ready_o;
    logic [7:0]  b_id_i = 0;
    logic [1:0]  b_resp_i = 0;
    logic        ar_valid_o, ar_ready_i = 0;
    logic [31:0] ar_addr_o;
    logic [7:0]  ar_id_o, ar_len_o, ar_user_o;
    logic [2:0]  ar_size_o, ar_prot_o;
    logic [1:0]  ar_burst_o;
    logic        r_valid_i = 0, r_ready_o, r_last_i = 1;
    logic [31:0] r_data_i = 0;
    logic [7:0]  r_id_i = 0;
    logic [1:0]  r_resp_i = 0;

    core_data_axi_master dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
        .aw_id_o(aw_id_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
        .aw_burst_o(aw_burst_o), .aw_prot_o(aw_prot_o), .aw_user_o(aw_user_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
        .w_strb_o(w_strb_o), .w_last_o(w_last_o), .w_user_o(w_user_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_id_i(b_id_i), .b_resp_i(b_resp_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_id_o(ar_id_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
        .ar_burst_o(ar_burst_o), .ar_prot_o(ar_prot_o), .ar_user_o(ar_user_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
        .r_id_i(r_id_i), .r_resp_i(r_resp_i), .r_last_i(r_last_i)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // slave latency and response settings
    int          aw_lat = 0, w_lat = 0, ar_lat = 0;
    bit          b_hold = 0;
    logic [1:0]  b_resp_k = AXI_RESP_OKAY, r_resp_k = AXI_RESP_OKAY;
    logic [31:0] r_data_k = 0;
    int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
    bit          aw_seen = 0, w_seen = 0, ar_seen = 0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0;
            aw_cyc = 0; w_cyc = 0; ar_cyc = 0;
        end else begin
            if (aw_valid_o) begin aw_ready_i = (aw_cyc >= aw_lat); aw_cyc++; end
            else begin aw_ready_i = 0; aw_cyc = 0; end
            if (w_valid_o) begin w_ready_i = (w_cyc >= w_lat); w_cyc++; end
            else begin w_ready_i = 0; w_cyc = 0; end
            if (ar_valid_o) begin ar_ready_i = (ar_cyc >= ar_lat); ar_cyc++; end
            else begin ar_ready_i = 0; ar_cyc = 0; end
            b_valid_i = aw_seen && w_seen && !b_hold;
            b_resp_i  = b_resp_k;
            r_valid_i = ar_seen;
            r_data_i  = r_data_k;
            r_resp_i  = r_resp_k;
        end
    end

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            aw_seen = 0; w_seen = 0; ar_seen = 0;
        end else begin
            if (b_valid_i && b_ready_o) begin aw_seen = 0; w_seen = 0; end
            if (r_valid_i && r_ready_o) ar_seen = 0;
            if (aw_valid_o && aw_ready_i) aw_seen = 1;
            if (w_valid_o && w_ready_i) w_seen = 1;
            if (ar_valid_o && ar_ready_i) ar_seen = 1;
        end
    end

    // monitor: response scoreboard, constant fields, gnt only in IDLE
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (data_rvalid_o) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_rvalid: got rvalid with empty scoreboard at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rdata", data_rdata_o, e.rdata);
                    check("err", {31'd0, data_err_o}, {31'd0, e.err});
                end
            end
            if (aw_valid_o)
                check("aw_const", {aw_id_o, aw_len_o, 5'd0, aw_size_o, aw_burst_o, aw_prot_o, 3'd0, w_last_o},
                      {8'd0, 8'd0, 5'd0, 3'b010, 2'b01, 3'b000, 3'd0, 1'b1});
            if (ar_valid_o)
                check("ar_const", {ar_id_o, ar_len_o, 5'd0, ar_size_o, ar_burst_o, ar_prot_o, 4'd0},
                      {8'd0, 8'd0, 5'd0, 3'b010, 2'b01, 3'b000, 4'd0});
            if (data_gnt_o) check("gnt_in_idle", {31'd0, dut.state == IDLE}, 32'd1);
        end
    end

    int cyc = 0, gnt_cnt = 0, outstanding = 0;
    int gnt_cyc_q[$];
    always @(posedge clk_i) begin
        cyc++;
        if (!rst_ni) outstanding = 0;
        else begin
            if (data_req_i && data_gnt_o) begin gnt_cnt++; gnt_cyc_q.push_back(cyc); end
            if ((aw_valid_o && aw_ready_i) || (ar_valid_o && ar_ready_i)) begin
                check("one_outstanding", outstanding, 0);
                outstanding = 1;
            end
            if (data_rvalid_o) outstanding = 0;
        end
    end

    // Called at a negedge; returns at the negedge of the cycle after the grant.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input bit keep, input bit push);
        bit granted = 0;
        data_req_i = 1; data_we_i = we; data_addr_i = addr; data_be_i = be; data_wdata_i = wdata;
        for (int i = 0; i < 50 && !granted; i++) begin
            #1;
            if (data_gnt_o) granted = 1;
            else @(negedge clk_i);
        end
        if (!granted) begin
            n_cmp++; n_err++;
            $display("FAIL gnt_timeout: no gnt for addr 0x%08h", addr);
        end else if (push) begin
            sb_q.push_back('{rdata: exp_rdata, err: exp_err});
        end
        @(negedge clk_i);
        if (!keep) data_req_i = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk_i);
        if (sb_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL rvalid_timeout: got %0d responses pending expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g0;
        repeat (3) @(negedge clk_i);
        check("rst_outputs", {23'd0, aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o,
                              data_gnt_o, data_rvalid_o, data_err_o, 1'b0}, 32'd0);
        check("rst_rdata", data_rdata_o, 32'd0);
        rst_ni = 1;
        @(negedge clk_i);
        check("idle_state", {29'd0, dut.state}, {29'd0, IDLE});

        // 1: zero-wait read, latency check
        r_data_k = 32'hDEADBEEF; r_resp_k = AXI_RESP_OKAY;
        do_req(0, 32'h0000_1004, 4'hF, 0, 32'hDEADBEEF, 0, 0, 1);
        check("t1_ar_valid", {31'd0, ar_valid_o}, 32'd1);
        check("t1_ar_addr", ar_addr_o, 32'h0000_1004);
        @(negedge clk_i);
        check("t2_r_ready", {31'd0, r_ready_o, ar_valid_o}, 32'b10);
        @(negedge clk_i);
        check("t3_rvalid", {31'd0, data_rvalid_o}, 32'd1);
        @(negedge clk_i);
        check("t4_rvalid_low", {31'd0, data_rvalid_o}, 32'd0);
        check("t4_rdata_hold", data_rdata_o, 32'hDEADBEEF);
        wait_done();

        // 2: write, W delayed 3 cycles after AW, EXOKAY response
        aw_lat = 0; w_lat = 3; b_resp_k = AXI_RESP_EXOKAY;
        do_req(1, 32'h2000_0000, 4'b0011, 32'h12345678, 32'h0, 0, 0, 1);
        check("w_t1_valids", {30'd0, aw_valid_o, w_valid_o}, 32'b11);
        check("w_t1_aw_addr", aw_addr_o, 32'h2000_0000);
        @(negedge clk_i);
        check("w_t2_valids", {30'd0, aw_valid_o, w_valid_o}, 32'b01);
        check("w_t2_strb", {28'd0, w_strb_o}, 32'b0011);
        check("w_t2_data", w_data_o, 32'h12345678);
        repeat (2) begin
            @(negedge clk_i);
            check("w_hold", {27'd0, w_valid_o, w_strb_o}, {27'd0, 1'b1, 4'b0011});
        end
        @(negedge clk_i);
        check("w_t5_bready", {30'd0, w_valid_o, b_ready_o}, 32'b01);
        wait_done();
        w_lat = 0; b_resp_k = AXI_RESP_OKAY;

        // 3: SLVERR read then clean read
        r_data_k = 32'hCAFEF00D; r_resp_k = AXI_RESP_SLVERR;
        do_req(0, 32'h0000_2000, 4'hF, 0, 32'h0, 1, 0, 1);
        wait_done();
        r_data_k = 32'h55AA1234; r_resp_k = AXI_RESP_OKAY;
        do_req(0, 32'h0000_2004, 4'hF, 0, 32'h55AA1234, 0, 0, 1);
        wait_done();

        // 4: back-to-back W, R, W with req held high
        g0 = gnt_cnt;
        gnt_cyc_q.delete();
        r_data_k = 32'h0BADF00D;
        do_req(1, 32'h3000_0000, 4'hF, 32'hA5A5_0001, 32'h0, 0, 1, 1);
        do_req(0, 32'h3000_0004, 4'hF, 32'h0, 32'h0BADF00D, 0, 1, 1);
        do_req(1, 32'h3000_0008, 4'hC, 32'hA5A5_0003, 32'h0, 0, 0, 1);
        wait_done();
        check("b2b_gnt_count", gnt_cnt - g0, 3);
        if (gnt_cyc_q.size() == 3) begin
            check("b2b_gnt_gap1", gnt_cyc_q[1] - gnt_cyc_q[0], 4);
            check("b2b_gnt_gap2", gnt_cyc_q[2] - gnt_cyc_q[1], 4);
        end

        // 5: reset while in WAIT_B, then a fresh read
        b_hold = 1;
        do_req(1, 32'h4000_0000, 4'hF, 32'h1111_2222, 32'h0, 0, 0, 0);
        for (int i = 0; i < 20 && !b_ready_o; i++) @(negedge clk_i);
        check("rst_wait_b", {31'd0, b_ready_o}, 32'd1);
        #2 rst_ni = 0;
        #1;
        check("rst_async_outputs", {27'd0, aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o}, 32'd0);
        check("rst_async_state", {29'd0, dut.state}, {29'd0, IDLE});
        @(negedge clk_i);
        b_hold = 0;
        rst_ni = 1;
        @(negedge clk_i);
        r_data_k = 32'h13579BDF;
        do_req(0, 32'h0000_0040, 4'hF, 0, 32'h13579BDF, 0, 0, 1);
        wait_done();

        // 6: W before AW, DECERR response
        aw_lat = 5; w_lat = 0; b_resp_k = AXI_RESP_DECERR;
        do_req(1, 32'h5000_0010, 4'hF, 32'h89ABCDEF, 32'h0, 1, 0, 1);
        check("wf_t1_valids", {30'd0, aw_valid_o, w_valid_o}, 32'b11);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("wf_aw_wait", {29'd0, aw_valid_o, w_valid_o, b_ready_o}, 32'b100);
        end
        @(negedge clk_i);
        check("wf_wait_b", {29'd0, aw_valid_o, w_valid_o, b_ready_o}, 32'b001);
        wait_done();

        repeat (3) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/core_data_axi_master.md
Name: core_data_axi_master

Overview:
- Bridges a CV32E40P-style core data port (req/gnt/rvalid) into single-beat AXI4 master transactions.
- It is the initiator counterpart of the AXI-to-memory slave path in the instruction subsystem.
- Placed between a core (or the debug/loader master) and the SoC AXI crossbar, so the core can reach AXI-attached memories and peripherals.
- One outstanding transaction at a time; no bursts.

Parameters:
AxiAddrWidth, 32, AXI and core address width
AxiDataWidth, 32, data width; only 32 supported (elaboration assertion)
AxiIdWidth, 8, AXI ID width
AxiUserWidth, 8, AXI user width; user fields driven 0
AxiId, 0, constant ID on AW/AR

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
data_req_i  in  1  core request
data_gnt_o  out  1  request accepted
data_addr_i  in  AxiAddrWidth  byte address
data_we_i  in  1  1=write
data_be_i  in  4  byte enables
data_wdata_i  in  32  write data
data_rvalid_o  out  1  response valid (one cycle per granted request, reads and writes)
data_rdata_o  out  32  read data
data_err_o  out  1  bus error, valid with rvalid
aw_valid_o/aw_ready_i, aw_addr_o(AxiAddrWidth), aw_id_o(AxiIdWidth), aw_len_o(8), aw_size_o(3), aw_burst_o(2), aw_prot_o(3)  AXI write address
w_valid_o/w_ready_i, w_data_o(32), w_strb_o(4), w_last_o(1)  AXI write data
b_valid_i/b_ready_o, b_id_i(AxiIdWidth), b_resp_i(2)  AXI write response
ar_valid_o/ar_ready_i, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o, ar_prot_o  AXI read address
r_valid_i/r_ready_o, r_data_i(32), r_id_i, r_resp_i(2), r_last_i  AXI read data

Behaviour:
- Reset values: all AXI valids/readies 0; data_gnt_o, data_rvalid_o, data_err_o 0; data_rdata_o 0; FSM in IDLE.
- Constant fields:
  - len=0, size=3'b010, burst=INCR (2'b01), prot=3'b000, w_last_o=1.
  - IDs=AxiId.
  - Addresses forwarded unmodified from the captured request.
- FSM states: IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP.
- IDLE:
  - data_gnt_o = data_req_i, combinational, only in IDLE.
  - On req, capture addr/we/be/wdata. Next state is WRITE if we=1, else READ.
- WRITE:
  - aw_valid_o and w_valid_o are both asserted from the first cycle.
  - Each is dropped independently after its own handshake (tracked by aw_done/w_done flags).
  - Both may complete in the same cycle or in either order.
  - Go to WAIT_B once both have completed, including completion in the current cycle.
  - Valid must not drop before ready.
- WAIT_B:
  - b_ready_o=1.
  - On b_valid_i, latch err = b_resp_i[1] and go to RESP.
- READ:
  - ar_valid_o=1 until ar_ready_i, then go to WAIT_R.
- WAIT_R:
  - r_ready_o=1.
  - On r_valid_i, latch rdata (forced to 0 if r_resp_i[1]) and err = r_resp_i[1], then go to RESP.
- RESP:
  - data_rvalid_o=1 for exactly one cycle, with data_err_o and data_rdata_o, then return to IDLE.
  - For writes, data_rdata_o=0.
  - Outside RESP: data_rvalid_o=0, data_err_o=0; data_rdata_o holds its last value.
- Latency with zero-wait slave:
  - Read: gnt at T0, AR handshake T1, R T2, rvalid T3.
  - Write: gnt T0, AW+W T1, B T2, rvalid T3.
  - Next gnt earliest at T4.
- Captured request is stable for the whole transaction; core inputs are ignored outside IDLE.
- OKAY and EXOKAY both count as success; SLVERR and DECERR set err.
- r_id/b_id mismatch is not checked functionally. The design includes an assertion that they equal AxiId.
- Reset asserted mid-transaction: immediate return to IDLE with all valids low; the pending transaction is abandoned. The system reset also resets slaves.

Decomposition:
- Package core_axi_master_pkg holds:
  - the state enum;
  - constants AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR.
- Single module, no sub-module. The AW/W done-flag logic is small enough to stay inline.

Test Plan:
- Read, zero-wait slave, addr 0x0000_1004, r_data 0xDEADBEEF, OKAY -> gnt T0, ar_addr 0x0000_1004 at T1, data_rvalid_o at T3 with rdata 0xDEADBEEF, err 0.
- Write, addr 0x2000_0000, data 0x12345678, be 4'b0011, w_ready delayed 3 cycles after aw_ready -> aw_valid drops after 1 cycle, w_strb 4'b0011 held until handshake, single rvalid after B, err 0.
- Read with r_resp SLVERR -> rvalid with err 1 and rdata 0x0; next read with OKAY returns clean data, err 0.
- Back-to-back: req held high for 3 requests (W, R, W) -> exactly 3 gnts, each only in IDLE, 3 rvalids in order, never more than one AXI transaction outstanding.
- rst_ni pulsed low while in WAIT_B -> all valids 0 and FSM in IDLE asynchronously; after release a fresh read completes normally.
- W handshake before AW (w_ready=1, aw_ready held 0 for 5 cycles) -> w_valid drops after the W handshake, aw_valid stays high, FSM enters WAIT_B only after the AW handshake.
